// File: rtl/frame_seq_pkg.sv
// Shared constants for the configuration-frame sequencer: header magic,
// header field positions and the sequencer state encoding.
package frame_seq_pkg;

  localparam logic [7:0] FRAME_SEQ_MAGIC = 8'hFA;

  localparam int MAGIC_MSB = 31;
  localparam int MAGIC_LSB = 24;
  localparam int COL_MSB   = 23;
  localparam int COL_LSB   = 19;
  localparam int FRAME_MSB = 18;
  localparam int FRAME_LSB = 14;
  localparam int COUNT_MSB = 13;
  localparam int COUNT_LSB = 0;

  localparam int COL_W   = COL_MSB - COL_LSB + 1;
  localparam int FRAME_W = FRAME_MSB - FRAME_LSB + 1;
  localparam int COUNT_W = COUNT_MSB - COUNT_LSB + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2
  } seqState_t;

endpackage

// File: rtl/frame_config_sequencer_if.sv
// Valid/ready configuration-word stream feeding the frame sequencer.
// The bitstream source is the master; the sequencer is the slave.
interface frame_config_sequencer_if #(
  parameter int DataWidth = 32
);
  logic [DataWidth-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/frame_onehot_dec.sv
// Binary frame index to one-hot row-frame strobe, forced to zero when
// the enable is low.
module frame_onehot_dec #(
  parameter int MaxFramesPerCol = 20,
  parameter int IndexWidth      = 5
) (
  input  logic [IndexWidth-1:0]      frameIndex,
  input  logic                       enable,
  output logic [MaxFramesPerCol-1:0] oneHot
);

  always_comb begin
    // NOTE: default every bit before the loop so no latch is inferred.
    oneHot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      if (enable && frameIndex == IndexWidth'(i)) oneHot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/frame_config_sequencer.sv
// Parses a header plus N data words and issues one column/frame write strobe
// per data word. Optional feature macro: FRAME_SEQ_FRAME_CNT_EN (strobe counter).
module frame_config_sequencer
  import frame_seq_pkg::*;
#(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int FrameBitsPerRow  = 32,
  parameter int NumCols          = 16
) (
  input  logic                        CLK,
  input  logic                        reset,
  frame_config_sequencer_if.slave     cfg,
  output logic [FrameBitsPerRow-1:0]  FrameData,
  output logic [FrameSelectWidth-1:0] FrameSelect,
  output logic                        FrameStrobe,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe_O,
  output logic                        busy,
  output logic                        err
`ifdef FRAME_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]                 frame_count
`endif
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_STROBE = STROBE;

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NumCols - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(MaxFramesPerCol - 1);

  logic [1:0]                  state;
  logic [COL_W-1:0]            column;
  logic [FRAME_W-1:0]          frame;
  logic [COUNT_W-1:0]          remaining;
  logic [MaxFramesPerCol-1:0]  decOneHot;

  logic [7:0]         hdrMagic;
  logic [COL_W-1:0]   hdrCol;
  logic [FRAME_W-1:0] hdrFrame;
  logic [COUNT_W-1:0] hdrCount;
  logic               hdrBad;
  logic               accept;
  logic               loadAccept;

  assign hdrMagic = cfg.in_data[MAGIC_MSB:MAGIC_LSB];
  assign hdrCol   = cfg.in_data[COL_MSB:COL_LSB];
  assign hdrFrame = cfg.in_data[FRAME_MSB:FRAME_LSB];
  assign hdrCount = cfg.in_data[COUNT_MSB:COUNT_LSB];
  assign hdrBad   = (hdrMagic != FRAME_SEQ_MAGIC) || (hdrCol > LAST_COL) ||
                    (hdrFrame > LAST_FRAME);

  // in_ready is gated by reset so the source sees it low while reset is held.
  assign cfg.in_ready = !reset && (state == ST_IDLE || state == ST_LOAD);
  assign accept       = cfg.in_valid && cfg.in_ready;
  assign loadAccept   = accept && (state == ST_LOAD);
  assign busy         = (state != ST_IDLE);

  frame_onehot_dec #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .IndexWidth     (FRAME_W)
  ) u_dec (
    .frameIndex(frame),
    .enable    (loadAccept),
    .oneHot    (decOneHot)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      column        <= '0;
      frame         <= '0;
      remaining     <= '0;
      FrameData     <= '0;
      FrameSelect   <= '0;
      FrameStrobe   <= 1'b0;
      FrameStrobe_O <= '0;
      err           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      FrameStrobe   <= loadAccept;
      FrameStrobe_O <= decOneHot;
      err           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (hdrBad) begin
              err <= 1'b1;
            end else if (hdrCount != '0) begin
              column    <= hdrCol;
              frame     <= hdrFrame;
              remaining <= hdrCount;
              state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            FrameData   <= cfg.in_data;
            FrameSelect <= FrameSelectWidth'(column);
            state       <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          remaining <= remaining - COUNT_W'(1);
          if (frame == LAST_FRAME) begin
            frame  <= '0;
            column <= column + COL_W'(1);
          end else begin
            frame <= frame + FRAME_W'(1);
          end
          // Running off the last column with frames still owed aborts the burst.
          if (remaining == COUNT_W'(1)) begin
            state <= ST_IDLE;
          end else if (frame == LAST_FRAME && column == LAST_COL) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FRAME_SEQ_FRAME_CNT_EN
  // Survives new headers; only reset clears it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (loadAccept && frame_count != 16'hFFFF) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: a per-cycle vector table plus
// hand-written sequences for reset mid-burst and the optional strobe counter.
module tb_frame_config_sequencer;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] FrameData;
  logic [4:0]  FrameSelect;
  logic        FrameStrobe;
  logic [19:0] FrameStrobe_O;
  logic        busy;
  logic        err;
`ifdef FRAME_SEQ_FRAME_CNT_EN
  logic [15:0] frameCount;
`endif

  int applied = 0;
  int miscompares = 0;

  frame_config_sequencer_if cfg ();

  frame_config_sequencer dut (
    .CLK          (CLK),
    .reset        (reset),
    .cfg          (cfg),
    .FrameData    (FrameData),
    .FrameSelect  (FrameSelect),
    .FrameStrobe  (FrameStrobe),
    .FrameStrobe_O(FrameStrobe_O),
    .busy         (busy),
`ifdef FRAME_SEQ_FRAME_CNT_EN
    .frame_count  (frameCount),
`endif
    .err          (err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] data;
    logic        expReady;
    logic        expStrobe;
    logic [4:0]  expSel;
    logic [19:0] expOneHot;
    logic [31:0] expData;
    logic        expBusy;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] WA = 32'hA000_0001;
  localparam logic [31:0] WB = 32'hB000_0002;
  localparam logic [31:0] WC = 32'hC000_0003;
  localparam logic [31:0] WD = 32'hD000_0004;
  localparam logic [31:0] WE = 32'hE000_0005;
  localparam logic [31:0] WF = 32'h0F0F_0006;
  localparam logic [31:0] WG = 32'h1234_5678;
  localparam logic [31:0] WH = 32'h8765_4321;
  localparam logic [31:0] WI = 32'h5A5A_0000;

  function automatic logic [31:0] hdr(input int col, input int frm, input int n);
    return {8'hFA, 5'(col), 5'(frm), 14'(n)};
  endfunction

  task automatic addRow(input logic rst, input logic vld, input logic [31:0] data,
                        input logic rdy, input logic stb, input logic [4:0] sel,
                        input logic [19:0] oh, input logic [31:0] fdata,
                        input logic bsy, input logic e);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = data;
    v.expReady = rdy; v.expStrobe = stb; v.expSel = sel; v.expOneHot = oh;
    v.expData = fdata; v.expBusy = bsy; v.expErr = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Offers a word until it is taken (bounded), then parks at the next negedge
  // with in_valid low.
  task automatic pushWord(input string tag, input logic [31:0] w);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge CLK);
      cfg.in_valid = 1'b1;
      cfg.in_data  = w;
      #1;
      if (cfg.in_ready === 1'b1) ok = 1'b1;
    end
    check({tag, " accepted"}, 32'(ok), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    cfg.in_valid = 1'b0;
  endtask

  task automatic checkStrobe(input string tag, input logic [4:0] sel,
                             input logic [19:0] oh, input logic [31:0] data);
    #1;
    check({tag, " FrameStrobe"}, 32'(FrameStrobe), 32'd1);
    check({tag, " FrameSelect"}, 32'(FrameSelect), 32'(sel));
    check({tag, " FrameStrobe_O"}, 32'(FrameStrobe_O), 32'(oh));
    check({tag, " FrameData"}, FrameData, data);
    check({tag, " in_ready"}, 32'(cfg.in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg.in_valid = 1'b0;
    cfg.in_data  = '0;
    #1 reset = 1'b1;

    //     rst vld data               rdy stb sel oh         fdata busy err
    addRow(1, 0, 32'd0,               0, 0, 0,  20'h0,     0,  0, 0);
    addRow(1, 0, 32'd0,               0, 0, 0,  20'h0,     0,  0, 0);
    addRow(0, 1, hdr(2, 0, 3),        1, 0, 0,  20'h0,     0,  0, 0);
    addRow(0, 1, WA,                  1, 0, 0,  20'h0,     0,  1, 0);
    addRow(0, 1, WB,                  0, 1, 2,  20'h1,     WA, 1, 0);
    addRow(0, 1, WB,                  1, 0, 2,  20'h0,     WA, 1, 0);
    addRow(0, 1, WC,                  0, 1, 2,  20'h2,     WB, 1, 0);
    addRow(0, 1, WC,                  1, 0, 2,  20'h0,     WB, 1, 0);
    addRow(0, 0, 32'd0,               0, 1, 2,  20'h4,     WC, 1, 0);
    addRow(0, 0, 32'd0,               1, 0, 2,  20'h0,     WC, 0, 0);
    // wrap from frame 19 of column 0 into column 1, with a stall in LOAD
    addRow(0, 1, hdr(0, 19, 2),       1, 0, 2,  20'h0,     WC, 0, 0);
    addRow(0, 0, 32'd0,               1, 0, 2,  20'h0,     WC, 1, 0);
    addRow(0, 1, WD,                  1, 0, 2,  20'h0,     WC, 1, 0);
    addRow(0, 1, WE,                  0, 1, 0,  20'h80000, WD, 1, 0);
    addRow(0, 1, WE,                  1, 0, 0,  20'h0,     WD, 1, 0);
    addRow(0, 0, 32'd0,               0, 1, 1,  20'h1,     WE, 1, 0);
    addRow(0, 0, 32'd0,               1, 0, 1,  20'h0,     WE, 0, 0);
    // bad magic, bad column, bad frame, then N=0
    addRow(0, 1, {8'hFB, 5'd1, 5'd0, 14'd1}, 1, 0, 1, 20'h0, WE, 0, 0);
    addRow(0, 0, 32'd0,               1, 0, 1,  20'h0,     WE, 0, 1);
    addRow(0, 1, hdr(16, 0, 1),       1, 0, 1,  20'h0,     WE, 0, 0);
    addRow(0, 0, 32'd0,               1, 0, 1,  20'h0,     WE, 0, 1);
    addRow(0, 1, hdr(3, 20, 1),       1, 0, 1,  20'h0,     WE, 0, 0);
    addRow(0, 0, 32'd0,               1, 0, 1,  20'h0,     WE, 0, 1);
    addRow(0, 1, hdr(3, 0, 0),        1, 0, 1,  20'h0,     WE, 0, 0);
    addRow(0, 0, 32'd0,               1, 0, 1,  20'h0,     WE, 0, 0);
    // running off the last column: one strobe, then err and back to IDLE
    addRow(0, 1, hdr(15, 19, 2),      1, 0, 1,  20'h0,     WE, 0, 0);
    addRow(0, 1, WF,                  1, 0, 1,  20'h0,     WE, 1, 0);
    addRow(0, 0, 32'd0,               0, 1, 15, 20'h80000, WF, 1, 0);
    addRow(0, 0, 32'd0,               1, 0, 15, 20'h0,     WF, 0, 1);
    addRow(0, 0, 32'd0,               1, 0, 15, 20'h0,     WF, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      reset        = vecs[i].rst;
      cfg.in_valid = vecs[i].vld;
      cfg.in_data  = vecs[i].data;
      #1;
      check($sformatf("row%0d in_ready", i), 32'(cfg.in_ready), 32'(vecs[i].expReady));
      check($sformatf("row%0d FrameStrobe", i), 32'(FrameStrobe), 32'(vecs[i].expStrobe));
      check($sformatf("row%0d FrameSelect", i), 32'(FrameSelect), 32'(vecs[i].expSel));
      check($sformatf("row%0d FrameStrobe_O", i), 32'(FrameStrobe_O), 32'(vecs[i].expOneHot));
      check($sformatf("row%0d FrameData", i), FrameData, vecs[i].expData);
      check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
      check($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].expErr));
    end
    @(negedge CLK);
    cfg.in_valid = 1'b0;

    // reset asserted in LOAD after one of three frames
    pushWord("mid hdr", hdr(4, 0, 3));
    pushWord("mid G", WG);
    checkStrobe("mid G", 5'd4, 20'h1, WG);
    @(negedge CLK);
    #1;
    check("mid load busy", 32'(busy), 32'd1);
    check("mid load in_ready", 32'(cfg.in_ready), 32'd1);
`ifdef FRAME_SEQ_FRAME_CNT_EN
    check("count before reset", 32'(frameCount), 32'd7);
`endif
    reset = 1'b1;
    #1;
    check("rst in_ready", 32'(cfg.in_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst FrameStrobe", 32'(FrameStrobe), 32'd0);
    check("rst FrameSelect", 32'(FrameSelect), 32'd0);
    check("rst FrameStrobe_O", 32'(FrameStrobe_O), 32'd0);
    check("rst FrameData", FrameData, 32'd0);
    check("rst err", 32'(err), 32'd0);
`ifdef FRAME_SEQ_FRAME_CNT_EN
    check("rst frame_count", 32'(frameCount), 32'd0);
`endif
    @(negedge CLK);
    reset = 1'b0;

    // fresh single-frame burst after the aborted one
    pushWord("fresh hdr", hdr(5, 3, 1));
    pushWord("fresh H", WH);
    checkStrobe("fresh H", 5'd5, 20'h8, WH);
    @(negedge CLK);
    #1;
    check("fresh idle busy", 32'(busy), 32'd0);
    check("fresh idle in_ready", 32'(cfg.in_ready), 32'd1);

    // second burst of four frames in column 6
    pushWord("burst hdr", hdr(6, 0, 4));
    for (int k = 0; k < 4; k++) begin
      pushWord($sformatf("burst I%0d", k), WI + 32'(k));
      checkStrobe($sformatf("burst I%0d", k), 5'd6, 20'(1 << k), WI + 32'(k));
    end
    @(negedge CLK);
    #1;
    check("burst idle busy", 32'(busy), 32'd0);
`ifdef FRAME_SEQ_FRAME_CNT_EN
    check("count two bursts", 32'(frameCount), 32'd5);
    reset = 1'b1;
    #1;
    check("count after reset", 32'(frameCount), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_config_sequencer.md
# frame_config_sequencer

Configuration-frame write controller for the fabric's column frame-select network. It takes a stream of 32-bit configuration words and parses a header plus N data words. For each data word it presents FrameData, then drives FrameSelect, FrameStrobe and a one-hot row-frame strobe for exactly one cycle. The per-column frame-select gates compare FrameSelect against their column index and forward the one-hot strobe into the tile frame latches. It sits between the bitstream source (UART/SPI/wishbone config port) and the fabric column strobe inputs.

## Interface
- MaxFramesPerCol, 20, frames per column; width of the row-frame strobe
- FrameSelectWidth, 5, column-select width
- FrameBitsPerRow, 32, FrameData width; equals the input word width
- NumCols, 16, number of columns present; legal column indices are 0..NumCols-1
- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_data  in  32  configuration word
- in_valid  in  1  in_data is valid
- in_ready  out  1  word accepted when in_valid && in_ready
- FrameData  out  FrameBitsPerRow  frame data, registered
- FrameSelect  out  FrameSelectWidth  target column, registered
- FrameStrobe  out  1  one-cycle write strobe, registered
- FrameStrobe_O  out  MaxFramesPerCol  one-hot frame index; nonzero only while FrameStrobe=1
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on a protocol error

## Operation
- Header word fields:
  - [31:24] magic 8'hFA
  - [23:19] start column
  - [18:14] start frame
  - [13:0] frame count N
- State IDLE: in_ready=1. On accept:
  - magic wrong, column ≥ NumCols, or start frame ≥ MaxFramesPerCol → err pulse, stay in IDLE, word dropped.
  - N=0 → stay in IDLE, no strobe.
  - Otherwise latch column, frame and remaining count (=N), then go to LOAD.
- State LOAD: in_ready=1. On accept: FrameData ← in_data, then go to STROBE.
- State STROBE: in_ready=0.
  - Drive FrameStrobe=1, FrameSelect=column, FrameStrobe_O=1<<frame for exactly one cycle.
  - Then decrement remaining and advance the frame.
  - Remaining reaches 0 → IDLE; otherwise → LOAD.
- Frame advance, wrap-around: frame=MaxFramesPerCol-1 → frame=0 and column+1.
  - If the new column would be ≥ NumCols while remaining>0: err pulse, abort to IDLE. That final strobe is still issued.
- FrameData holds its value after STROBE until the next LOAD accept.
- In all non-strobe cycles, FrameStrobe=0 and FrameStrobe_O=0. FrameSelect holds its last value.
- in_valid low in LOAD: wait indefinitely. No timeout.

## Timing
- Reset values: in_ready=0 while reset is asserted, then 1 (IDLE). All other outputs are 0.
- Reset asserted mid-burst: immediate return to IDLE and all outputs cleared. Any partial burst is discarded.
- Latency: a data word accepted in cycle t gives FrameStrobe=1 in cycle t+1.
- Sustained rate: one frame per 2 cycles.
- The header costs 1 cycle. First strobe is no earlier than header+2.
- err is registered and asserts the cycle after the offending accept or advance.

## Configuration
- FRAME_SEQ_FRAME_CNT_EN:
  - Defined: adds output frame_count [15:0]. Counts issued strobes, saturates at 16'hFFFF, is cleared by reset, and is not cleared by a new header.
  - Undefined: no port and no counter logic.

## Structure
- Package frame_seq_pkg holds:
  - magic constant FRAME_SEQ_MAGIC=8'hFA
  - header field LSB/MSB localparams
  - state enum {IDLE, LOAD, STROBE}
- One sub-module is natural: frame_onehot_dec. It maps the binary frame index to MaxFramesPerCol one-hot bits and is gated by an enable.

## Test plan
- Header col=2, frame=0, N=3, data A/B/C with in_valid held: strobes in 3 cycles, 2 apart. FrameSelect=2; FrameStrobe_O=0x1, 0x2, 0x4; FrameData=A, B, C at each strobe. Then IDLE.
- Header col=0, frame=19, N=2: first strobe col=0, FrameStrobe_O=1<<19; second strobe col=1, FrameStrobe_O=0x1 (wrap).
- Header magic 8'hFB → err pulse next cycle, no strobe, in_ready stays 1. Header col=16 → same.
- Header col=15, frame=19, N=2: one strobe on col 15, then err pulse and return to IDLE.
- Reset asserted in LOAD after 1 of 3 frames: all outputs 0 the same cycle. A fresh header afterwards works normally.
- With FRAME_SEQ_FRAME_CNT_EN defined: 5 frames over two bursts → frame_count=5. Reset → 0.
